axi2apb_req_arb: RTL



---
 rtl/axi2apb_req_arb_if.sv | 35 +++
 rtl/axi2apb_req_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axi2apb_req_arb_if.sv
// ---------------------------------------------------------------------------
// axi2apb_req_arb_if
// Shared-port bundle between the requester arbiter and the APB sequencer of
// the AXI-to-APB bridge.
//   master : arbiter side   - drives REQ/ADDR/WR/DATAW/BE/PROT,
//                             receives ACK/DATAR/ERROR
//   slave  : sequencer side - mirror of master
// Parameters: WIDTH_PAD (address width), WIDTH_PDA (data width),
//             WIDTH_PDS (byte-enable width).
// ---------------------------------------------------------------------------
interface axi2apb_req_arb_if #(
    parameter int WIDTH_PAD = 32,
    parameter int WIDTH_PDA = 32,
    parameter int WIDTH_PDS = (WIDTH_PDA / 8)
) ();
    logic                 REQ;
    logic                 ACK;
    logic [WIDTH_PAD-1:0] ADDR;
    logic                 WR;
    logic [WIDTH_PDA-1:0] DATAW;
    logic [WIDTH_PDS-1:0] BE;
    logic [2:0]           PROT;
    logic [WIDTH_PDA-1:0] DATAR;
    logic                 ERROR;

    modport master (
        output REQ, ADDR, WR, DATAW, BE, PROT,
        input  ACK, DATAR, ERROR
    );

    modport slave (
        input  REQ, ADDR, WR, DATAW, BE, PROT,
        output ACK, DATAR, ERROR
    );
endinterface

// File: rtl/axi2apb_req_arb.sv
// ---------------------------------------------------------------------------
// axi2apb_req_arb
// Round-robin arbiter sharing one APB-sequencer REQ/ACK port among NUM_REQ
// requesters. Four-phase REQ/ACK on both sides; the grant is registered, the
// winner's command fields are muxed onto the shared port, and read data /
// error are returned to the winner only.
//
// Ports:
//   ACLK, ARESET  clock, synchronous active-high reset
//   REQ_IN        per-requester request (bit i = requester i)
//   ACK_OUT       per-requester acknowledge
//   ADDR_IN, WR_IN, DATAW_IN, BE_IN, PROT_IN
//                 packed per-requester command fields (slice i = requester i)
//   DATAR_OUT     captured read data, common to all requesters, held until
//                 the next capture
//   ERROR_OUT     per-requester error, valid while ACK_OUT[i]=1
//   GRANT         one-hot current grant (debug)
//   apb           shared sequencer port (master modport)
//   LOCK_IN       only with AXI2APB_ARB_LOCK_EN: the just-finished requester
//                 is re-granted ahead of round-robin order if it still
//                 requests when the arbiter returns to IDLE
//
// Optional feature macro: AXI2APB_ARB_LOCK_EN
// ---------------------------------------------------------------------------
module axi2apb_req_arb #(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH_PAD = 32,
    parameter int WIDTH_PDA = 32,
    parameter int WIDTH_PDS = (WIDTH_PDA / 8)
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [NUM_REQ-1:0]             REQ_IN,
    output logic [NUM_REQ-1:0]             ACK_OUT,
    input  logic [NUM_REQ*WIDTH_PAD-1:0]   ADDR_IN,
    input  logic [NUM_REQ-1:0]             WR_IN,
    input  logic [NUM_REQ*WIDTH_PDA-1:0]   DATAW_IN,
    input  logic [NUM_REQ*WIDTH_PDS-1:0]   BE_IN,
    input  logic [NUM_REQ*3-1:0]           PROT_IN,
    output logic [WIDTH_PDA-1:0]           DATAR_OUT,
    output logic [NUM_REQ-1:0]             ERROR_OUT,
`ifdef AXI2APB_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             LOCK_IN,
`endif
    output logic [NUM_REQ-1:0]             GRANT,
    axi2apb_req_arb_if.master              apb
);

    localparam int IDXW = $clog2(NUM_REQ);
    typedef logic [IDXW-1:0] idx_t;

    localparam logic [NUM_REQ-1:0] GRANT_LSB = NUM_REQ'(1);
    localparam idx_t               IDX_LAST  = idx_t'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_REL,
        WAIT_ACKLOW
    } state_t;

    state_t state;
    idx_t   rr_last;
    idx_t   g_idx;      // index of the current / most recent grant
    logic   req;

`ifdef AXI2APB_ARB_LOCK_EN
    logic   lock_pend;  // lock seen on the WAIT_ACKLOW -> IDLE transition
`endif

    // Round-robin pick: first set REQ_IN bit after rr_last, wrapping.
    idx_t pick_idx;
    idx_t cand;
    logic pick_valid;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = idx_t'((32'(rr_last) + k) % NUM_REQ);
            if (!pick_valid && REQ_IN[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Command mux: AND-OR of slices under the one-hot grant, zero when idle.
    logic [WIDTH_PAD-1:0] addr_mux;
    logic                 wr_mux;
    logic [WIDTH_PDA-1:0] dataw_mux;
    logic [WIDTH_PDS-1:0] be_mux;
    logic [2:0]           prot_mux;

    always_comb begin
        addr_mux  = '0;
        wr_mux    = 1'b0;
        dataw_mux = '0;
        be_mux    = '0;
        prot_mux  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (GRANT[i]) begin
                addr_mux  = addr_mux  | ADDR_IN[i*WIDTH_PAD +: WIDTH_PAD];
                wr_mux    = wr_mux    | WR_IN[i];
                dataw_mux = dataw_mux | DATAW_IN[i*WIDTH_PDA +: WIDTH_PDA];
                be_mux    = be_mux    | BE_IN[i*WIDTH_PDS +: WIDTH_PDS];
                prot_mux  = prot_mux  | PROT_IN[i*3 +: 3];
            end
        end
    end

    assign apb.REQ   = req;
    assign apb.ADDR  = addr_mux;
    assign apb.WR    = wr_mux;
    assign apb.DATAW = dataw_mux;
    assign apb.BE    = be_mux;
    assign apb.PROT  = prot_mux;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            rr_last   <= IDX_LAST;
            g_idx     <= '0;
            req       <= 1'b0;
            GRANT     <= '0;
            ACK_OUT   <= '0;
            ERROR_OUT <= '0;
            DATAR_OUT <= '0;
`ifdef AXI2APB_ARB_LOCK_EN
            lock_pend <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef AXI2APB_ARB_LOCK_EN
                    // Lock only applies on the first IDLE edge; rr_last is
                    // left alone so the rotation resumes where it was.
                    lock_pend <= 1'b0;
                    if (lock_pend && REQ_IN[g_idx]) begin
                        GRANT <= GRANT_LSB << g_idx;
                        req   <= 1'b1;
                        state <= WAIT_ACK;
                    end else
`endif
                    if (pick_valid) begin
                        GRANT   <= GRANT_LSB << pick_idx;
                        g_idx   <= pick_idx;
                        rr_last <= pick_idx;
                        req     <= 1'b1;
                        state   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (apb.ACK) begin
                        DATAR_OUT        <= apb.DATAR;
                        ERROR_OUT[g_idx] <= apb.ERROR;
                        ACK_OUT[g_idx]   <= 1'b1;
                        state            <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!REQ_IN[g_idx]) begin
                        req   <= 1'b0;
                        state <= WAIT_ACKLOW;
                    end
                end
                WAIT_ACKLOW: begin
                    if (!apb.ACK) begin
                        ACK_OUT   <= '0;
                        ERROR_OUT <= '0;
                        GRANT     <= '0;
                        state     <= IDLE;
`ifdef AXI2APB_ARB_LOCK_EN
                        lock_pend <= LOCK_IN[g_idx];
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
